// File: rtl/strobe_counter.sv
// Parameterised event/sequence counter for SD-card read datapath word/bit/CRC counting.
// Optional synchronous clear port `clr` is enabled by defining STROBE_COUNTER_SYNC_CLR_EN.
module strobe_counter #(
  parameter int          DW   = 8,
  parameter int unsigned MAX  = 32'h40,
  parameter int          MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
`ifdef STROBE_COUNTER_SYNC_CLR_EN
  input  logic          clr,
`endif
  input  logic          enable,
  input  logic          start_strb,
  output logic [DW-1:0] cntr,
  output logic          strb,
  output logic          busy
);

  localparam longint unsigned LIMIT = 64'd1 << DW;

  if (DW < 1 || DW > 32) begin : g_bad_dw
    $error("strobe_counter: DW must be in 1..32");
  end
  if (64'(MAX) >= LIMIT) begin : g_bad_max
    $error("strobe_counter: MAX must be below 2**DW");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("strobe_counter: MODE must be 0 or 1");
  end

  localparam logic [DW-1:0] MAX_C    = MAX[DW-1:0];
  localparam logic [DW-1:0] ONE      = DW'(1);
  // MAX == 0 is degenerate: in MODE 0 the counter and strobe stay at 0 forever.
  localparam bit            MAX_ZERO = (MAX == 0);

  logic [DW-1:0] cntr_d;
  logic [DW-1:0] cntr_inc;
  logic          strb_d;
  logic          busy_d;

  assign cntr_inc = cntr + ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    cntr_d = cntr;
    strb_d = strb;
    busy_d = busy;

    if (MODE == 0) begin
      busy_d = 1'b0;
      if (MAX_ZERO) begin
        cntr_d = '0;
        strb_d = 1'b0;
      end else if (strb) begin
        // Terminal cycle auto-clears, but an event arriving now is still counted.
        cntr_d = enable ? ONE : '0;
        strb_d = enable && (ONE == MAX_C);
      end else if (enable) begin
        cntr_d = cntr_inc;
        strb_d = (cntr_inc == MAX_C);
      end
    end else begin
      if (start_strb) begin
        cntr_d = '0;
        busy_d = 1'b1;
        strb_d = MAX_ZERO;
      end else if (busy && enable) begin
        if (cntr == MAX_C) begin
          cntr_d = '0;
          busy_d = 1'b0;
          strb_d = 1'b0;
        end else begin
          cntr_d = cntr_inc;
          strb_d = (cntr_inc == MAX_C);
        end
      end else if (!busy) begin
        cntr_d = '0;
        strb_d = 1'b0;
      end
    end

`ifdef STROBE_COUNTER_SYNC_CLR_EN
    if (clr) begin
      cntr_d = '0;
      strb_d = 1'b0;
      busy_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntr <= '0;
      strb <= 1'b0;
      busy <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all three update together.
      cntr <= cntr_d;
      strb <= strb_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_strobe_counter.sv
// Self-checking bench for strobe_counter: one MODE 0 (DW=8, MAX=0x40) and one MODE 1
// (DW=6, MAX=0x3E) instance, checked every cycle against a behavioural model.
module tb_strobe_counter;

  localparam int M0_MAX = 'h40;
  localparam int M1_MAX = 'h3E;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] d0_cntr;
  logic       d0_strb, d0_busy;
  logic [5:0] d1_cntr;
  logic       d1_strb, d1_busy;

  int checks = 0;
  int errors = 0;
  bit chain = 1'b0;
  bit chain_ext = 1'b0;

  // Behavioural model: plain integers tracking count position and sequence-running flag.
  int m0_cnt = 0;
  bit m1_run = 1'b0;
  int m1_pos = 0;

  always #5 clk = ~clk;

  strobe_counter #(.DW(8), .MAX(8'h40), .MODE(0)) u_ev (
    .clk        (clk),
    .reset      (reset),
`ifdef STROBE_COUNTER_SYNC_CLR_EN
    .clr        (clr),
`endif
    .enable     (en0),
    .start_strb (start1),
    .cntr       (d0_cntr),
    .strb       (d0_strb),
    .busy       (d0_busy)
  );

  strobe_counter #(.DW(6), .MAX(6'h3E), .MODE(1)) u_seq (
    .clk        (clk),
    .reset      (reset),
`ifdef STROBE_COUNTER_SYNC_CLR_EN
    .clr        (clr),
`endif
    .enable     (en1),
    .start_strb (start1),
    .cntr       (d1_cntr),
    .strb       (d1_strb),
    .busy       (d1_busy)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit use_clr;
    use_clr = 1'b0;
`ifdef STROBE_COUNTER_SYNC_CLR_EN
    use_clr = clr;
`endif
    if (!reset || use_clr) begin
      m0_cnt = 0;
      m1_run = 1'b0;
      m1_pos = 0;
      return;
    end
    if (m0_cnt == M0_MAX) m0_cnt = en0 ? 1 : 0;
    else if (en0)         m0_cnt = m0_cnt + 1;

    if (start1) begin
      m1_run = 1'b1;
      m1_pos = 0;
    end else if (m1_run && en1) begin
      if (m1_pos == M1_MAX) begin
        m1_run = 1'b0;
        m1_pos = 0;
      end else begin
        m1_pos = m1_pos + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ev_cntr",  d0_cntr, m0_cnt);
    check("ev_strb",  d0_strb, (m0_cnt == M0_MAX) ? 1 : 0);
    check("ev_busy",  d0_busy, 0);
    check("seq_cntr", d1_cntr, m1_run ? m1_pos : 0);
    check("seq_strb", d1_strb, (m1_run && m1_pos == M1_MAX) ? 1 : 0);
    check("seq_busy", d1_busy, m1_run);
  endtask

  // Inputs are stable from 1 time unit after one edge until the next edge.
  task automatic step();
    if (chain) start1 = d1_strb | chain_ext;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // Steps until the sequence strobe rises; n = edges taken (bounded).
  task automatic wait_seq_strb(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!d1_strb && n < limit);
  endtask

  initial begin
    int n;
    int strb_cycles;
    int max_seen;

    // Reset held low: outputs zero before any edge and across edges.
    #2;
    check("rst_ev_cntr", d0_cntr, 0);
    check("rst_seq_busy", d1_busy, 0);
    en0 = 1'b1; en1 = 1'b1; start1 = 1'b1;
    step();
    step();
    en0 = 1'b0; en1 = 1'b0; start1 = 1'b0;
    reset = 1'b1;
    step();

    // MODE 0: 64 gapped pulses, one-cycle terminal strobe, then auto-clear.
    strb_cycles = 0;
    for (int i = 0; i < M0_MAX; i++) begin
      en0 = 1'b1; step();
      if (d0_strb) strb_cycles++;
      en0 = 1'b0;
      if (i == M0_MAX - 1) check("ev_at_max", d0_cntr, 'h40);
      step();
      if (d0_strb) strb_cycles++;
    end
    check("ev_strb_once", strb_cycles, 1);
    check("ev_cleared", d0_cntr, 0);

    // MODE 0: event arriving in the strobe cycle is not lost.
    for (int i = 0; i < M0_MAX; i++) begin
      en0 = 1'b1; step();
      if (i != M0_MAX - 1) begin
        en0 = 1'b0; step();
      end
    end
    check("ev_strb_hi", d0_strb, 1);
    step();
    en0 = 1'b0;
    check("ev_no_loss", d0_cntr, 1);
    check("ev_no_loss_strb", d0_strb, 0);
    for (int i = 0; i < M0_MAX + 2; i++) begin
      en0 = 1'b1; step();
    end
    en0 = 1'b0;
    repeat (2) step();

    // MODE 1: single start with enable high; strobe after MAX edges, then idle.
    en1 = 1'b1; start1 = 1'b1; step();
    start1 = 1'b0;
    wait_seq_strb(200, n);
    check("seq_latency", n, M1_MAX);
    check("seq_at_max", d1_cntr, 'h3E);
    step();
    check("seq_idle_busy", d1_busy, 0);
    check("seq_idle_cntr", d1_cntr, 0);
    strb_cycles = 0;
    repeat (20) begin
      step();
      if (d1_strb) strb_cycles++;
    end
    check("seq_no_extra", strb_cycles, 0);

    // MODE 1: restart at 0x10 zeroes and reruns the full count.
    start1 = 1'b1; step();
    start1 = 1'b0;
    repeat (16) step();
    check("seq_pre_restart", d1_cntr, 'h10);
    start1 = 1'b1; step();
    start1 = 1'b0;
    check("seq_restart", d1_cntr, 0);
    wait_seq_strb(200, n);
    check("seq_restart_latency", n, M1_MAX);
    step();

    // MODE 1: five-cycle enable gap freezes count and delays strobe.
    start1 = 1'b1; step();
    start1 = 1'b0;
    repeat (20) step();
    en1 = 1'b0;
    repeat (5) step();
    check("seq_frozen", d1_cntr, 20);
    en1 = 1'b1;
    wait_seq_strb(200, n);
    check("seq_hold_latency", n, M1_MAX - 20);
    step();

    // MODE 1 chaining: strobe fed back into start gives period MAX+1.
    chain = 1'b1; chain_ext = 1'b1;
    step();
    chain_ext = 1'b0;
    wait_seq_strb(200, n);
    max_seen = 0;
    for (int p = 0; p < 10; p++) begin
      n = 0;
      do begin
        step();
        n++;
        if (int'(d1_cntr) > max_seen) max_seen = int'(d1_cntr);
      end while (!d1_strb && n < 200);
      check("chain_period", n, M1_MAX + 1);
    end
    check("chain_max", max_seen, M1_MAX);
    chain = 1'b0;
    start1 = 1'b0;
    en1 = 1'b0;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en0    = ($urandom_range(3) != 0);
      en1    = ($urandom_range(3) != 0);
      start1 = ($urandom_range(40) == 0);
`ifdef STROBE_COUNTER_SYNC_CLR_EN
      clr    = ($urandom_range(100) == 0);
`endif
      step();
    end
    clr = 1'b0;

    // Async reset mid-operation: outputs clear between edges.
    en0 = 1'b1; en1 = 1'b1; start1 = 1'b1; step();
    start1 = 1'b0;
    repeat (10) step();
    #3;
    reset = 1'b0;
    #1;
    check("async_ev_cntr", d0_cntr, 0);
    check("async_seq_cntr", d1_cntr, 0);
    check("async_seq_busy", d1_busy, 0);
    check("async_seq_strb", d1_strb, 0);
    repeat (2) step();
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    step();

`ifdef STROBE_COUNTER_SYNC_CLR_EN
    // clr beats a simultaneous start.
    en1 = 1'b1; start1 = 1'b1; step();
    start1 = 1'b0;
    repeat (32) step();
    check("clr_pre", d1_cntr, 'h20);
    clr = 1'b1; start1 = 1'b1; step();
    clr = 1'b0; start1 = 1'b0;
    check("clr_cntr", d1_cntr, 0);
    check("clr_busy", d1_busy, 0);
    check("clr_strb", d1_strb, 0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
